// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: op encodings and op decode helpers.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  // Signed ops are MULT/DIV (even encodings).
  function automatic logic op_signed(input logic [1:0] o);
    return ~o[0];
  endfunction

  // Divide ops are DIV/DIVU (upper encoding bit set).
  function automatic logic op_is_div(input logic [1:0] o);
    return o[1];
  endfunction

endpackage

// File: rtl/mdu_addsub.sv
// (W)-bit adder/subtractor with carry-out; cout=1 on subtract means no borrow.
module mdu_addsub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  // Subtraction as x + ~y + 1.
  always_comb begin
    full = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{W{1'b0}}, sub};
    sum  = full[W-1:0];
    cout = full[W];
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide, HI/LO results.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         div_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int unsigned CW = $clog2(N);

  logic [1:0]     state_q;
  logic [1:0]     op_q;
  logic           sign_a_q, sign_b_q;
  logic [CW-1:0]  cnt_q;
  // Multiply: m_q = multiplicand, acc = {partial product, remaining multiplier bits}.
  // Divide:   m_q = divisor,      acc = {partial remainder, dividend -> quotient}.
  logic [N-1:0]   m_q;
  logic [2*N-1:0] acc_q;
  logic [N-1:0]   hi_q, lo_q;
  logic           div_zero_q;

  logic           neg_a, neg_b;
  logic [N-1:0]   mag_a, mag_b;
  logic [N:0]     as_x, as_y, as_sum;
  logic           as_sub, as_cout;
  logic [N:0]     mul_hi;
  logic [N-1:0]   rem_next;
  logic [2*N-1:0] acc_step;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix, rem_fix;
  logic [N-1:0]   res_hi, res_lo;

  mdu_addsub #(
    .W(N + 1)
  ) u_addsub (
    .x   (as_x),
    .y   (as_y),
    .sub (as_sub),
    .sum (as_sum),
    .cout(as_cout)
  );

  // Operand magnitudes at acceptance; raw values for unsigned ops.
  always_comb begin
    neg_a = op_signed(op) & inA[N-1];
    neg_b = op_signed(op) & inB[N-1];
    mag_a = neg_a ? -inA : inA;
    mag_b = neg_b ? -inB : inB;
  end

  // One iteration: shared adder does the accumulate add or the trial subtraction.
  always_comb begin
    as_y     = {1'b0, m_q};
    as_x     = {1'b0, acc_q[2*N-1:N]};
    as_sub   = 1'b0;
    if (op_is_div(op_q)) begin
      as_x   = {acc_q[2*N-1:N], acc_q[N-1]};
      as_sub = 1'b1;
    end
    mul_hi   = acc_q[0] ? as_sum : {1'b0, acc_q[2*N-1:N]};
    // Remainder always fits in N bits: either below the divisor or the restored value.
    rem_next = as_cout ? as_sum[N-1:0] : as_x[N-1:0];
    if (op_is_div(op_q)) begin
      acc_step = {rem_next, acc_q[N-2:0], as_cout};
    end else begin
      acc_step = {mul_hi, acc_q[N-1:1]};
    end
  end

  // Sign correction applied in FIX; unsigned ops pass through.
  always_comb begin
    prod_fix = acc_q;
    quo_fix  = acc_q[N-1:0];
    rem_fix  = acc_q[2*N-1:N];
    if (op_signed(op_q)) begin
      if (sign_a_q ^ sign_b_q) begin
        prod_fix = -acc_q;
        quo_fix  = -acc_q[N-1:0];
      end
      if (sign_a_q) begin
        rem_fix = -acc_q[2*N-1:N];
      end
    end
    if (op_is_div(op_q)) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[2*N-1:N];
      res_lo = prod_fix[N-1:0];
    end
  end

  // FSM, iteration counter, shift registers and HI/LO result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= 2'd0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      cnt_q      <= '0;
      m_q        <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q       <= op;
            sign_a_q   <= neg_a;
            sign_b_q   <= neg_b;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
            if (op_is_div(op) && (inB == '0)) begin
              hi_q       <= inA;
              lo_q       <= '1;
              div_zero_q <= 1'b1;
              state_q    <= DONE;
            end else if (op_is_div(op)) begin
              m_q     <= mag_b;
              acc_q   <= {{N{1'b0}}, mag_a};
              state_q <= CALC;
            end else begin
              m_q     <= mag_a;
              acc_q   <= {{N{1'b0}}, mag_b};
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu (N=32).
module tb_mdu;
  import mdu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'd0;
  logic [31:0] inA   = '0;
  logic [31:0] inB   = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;

  mdu #(
    .N(32)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .inA     (inA),
    .inB     (inB),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present a request for one posedge (cycle 0); afterwards we observe cycle 1.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit keep);
    start = 1'b1;
    op    = o;
    inA   = a;
    inB   = b;
    tick();
    if (!keep) start = 1'b0;
  endtask

  // Wait for done; lat is the cycle number at which done is observed.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = 1;
    busy_ok = busy;
    while (!done && lat < 200) begin
      tick();
      lat++;
      busy_ok = busy_ok & busy;
    end
  endtask

  int lat;
  bit busy_ok;
  bit hold_ok;
  bit no_done;

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);

    // MULTU max x max
    launch(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done(lat, busy_ok);
    check("multu_lat", 64'(lat), 64'd34);
    check("multu_busy", 64'(busy_ok), 64'd1);
    check("multu_hi", 64'(hi), 64'hFFFFFFFE);
    check("multu_lo", 64'(lo), 64'h00000001);
    tick();
    check("multu_done_pulse", 64'(done), 64'd0);
    check("multu_idle", 64'(busy), 64'd0);
    check("multu_hold_lo", 64'(lo), 64'h00000001);

    // MULT -3 x 7
    launch(MDU_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
    wait_done(lat, busy_ok);
    check("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
    check("mult_neg_lo", 64'(lo), 64'hFFFFFFEB);
    tick();

    // MULT min x min
    launch(MDU_MULT, 32'h80000000, 32'h80000000, 1'b0);
    wait_done(lat, busy_ok);
    check("mult_min_hi", 64'(hi), 64'h40000000);
    check("mult_min_lo", 64'(lo), 64'h0);
    tick();

    // DIVU 100 / 7
    launch(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    wait_done(lat, busy_ok);
    check("divu_lat", 64'(lat), 64'd34);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);
    check("divu_dz", 64'(div_zero), 64'd0);
    tick();

    // DIV -7 / 2
    launch(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_done(lat, busy_ok);
    check("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFFFFFF);
    tick();

    // DIV 7 / -2: remainder follows dividend sign
    launch(MDU_DIV, 32'd7, 32'hFFFFFFFE, 1'b0);
    wait_done(lat, busy_ok);
    check("div_negb_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_negb_hi", 64'(hi), 64'd1);
    tick();

    // DIV overflow -2^31 / -1
    launch(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_done(lat, busy_ok);
    check("div_ovf_lo", 64'(lo), 64'h80000000);
    check("div_ovf_hi", 64'(hi), 64'h0);
    tick();

    // DIV by zero
    launch(MDU_DIV, 32'h1234, 32'd0, 1'b0);
    wait_done(lat, busy_ok);
    check("dz_lat", 64'(lat), 64'd1);
    check("dz_flag", 64'(div_zero), 64'd1);
    check("dz_hi", 64'(hi), 64'h1234);
    check("dz_lo", 64'(lo), 64'hFFFFFFFF);
    tick();
    check("dz_flag_held", 64'(div_zero), 64'd1);

    // MULTU 2 x 3 clears div_zero at acceptance
    launch(MDU_MULTU, 32'd2, 32'd3, 1'b0);
    check("dz_clear", 64'(div_zero), 64'd0);
    wait_done(lat, busy_ok);
    check("multu6_lo", 64'(lo), 64'd6);
    check("multu6_hi", 64'(hi), 64'd0);
    tick();

    // start held high with changing operands during the op
    launch(MDU_MULTU, 32'd5, 32'd7, 1'b1);
    lat     = 1;
    hold_ok = 1'b1;
    while (!done && lat < 200) begin
      hold_ok = hold_ok & (hi === 32'd0) & (lo === 32'd6);
      op  = MDU_DIV;
      inA = 32'd100 + 32'(lat);
      inB = 32'd0;
      tick();
      lat++;
    end
    check("held_hold", 64'(hold_ok), 64'd1);
    check("held_lat", 64'(lat), 64'd34);
    check("held_lo", 64'(lo), 64'd35);
    check("held_hi", 64'(hi), 64'd0);
    op  = MDU_MULTU;
    inA = 32'd9;
    inB = 32'd4;
    tick();
    check("held_c35_idle", 64'(busy), 64'd0);
    tick();
    check("held_c36_busy", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(lat, busy_ok);
    check("held2_lat", 64'(lat), 64'd34);
    check("held2_lo", 64'(lo), 64'd36);
    tick();

    // Reset mid-DIVU at cycle 10
    launch(MDU_DIVU, 32'd1000, 32'd3, 1'b0);
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    no_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      no_done = no_done & ~done;
      tick();
    end
    check("mid_rst_nodone", 64'(no_done), 64'd1);
    launch(MDU_DIVU, 32'd1000, 32'd3, 1'b0);
    wait_done(lat, busy_ok);
    check("post_rst_lat", 64'(lat), 64'd34);
    check("post_rst_lo", 64'(lo), 64'd333);
    check("post_rst_hi", 64'(hi), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
